// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// bus_arbiter : CPU/DMA arbiter for one shared fixed-latency 16-bit memory port
// Revision    : 1.0
// ============================================================================
module bus_arbiter #(
  parameter int WAIT_CYC = 1,
  parameter bit CPU_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic [15:0] c_addr,
  input  logic        c_rw,
  input  logic [15:0] c_wdata,
  output logic [15:0] c_rdata,
  output logic        c_ack,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic        d_rw,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic        m_en,
  output logic [15:0] m_addr,
  output logic        m_rw,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  output logic        busy,
  output logic        owner
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] cnt;
  logic       grant_c;
  logic       grant_d;

  // On a tie the CPU wins under fixed priority, or when the DMA had the last turn
  assign grant_c = c_req && (!d_req || CPU_PRIO || owner);
  assign grant_d = d_req && !grant_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (c_req || d_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_en  = 1'b0;
    busy  = 1'b0;
    c_ack = 1'b0;
    d_ack = 1'b0;
    case (state)
      ACCESS: begin
        m_en = 1'b1;
        busy = 1'b1;
      end
      DONE: begin
        busy  = 1'b1;
        c_ack = !owner;
        d_ack = owner;
      end
      default: ;
    endcase
  end

  // Owner resets to DMA so the first round-robin tie goes to the CPU
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner   <= 1'b1;
      m_addr  <= 16'h0000;
      m_rw    <= 1'b1;
      m_wdata <= 16'h0000;
      cnt     <= 4'd0;
      c_rdata <= 16'h0000;
      d_rdata <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (grant_c || grant_d) begin
            owner   <= grant_d;
            m_addr  <= grant_d ? d_addr  : c_addr;
            m_rw    <= grant_d ? d_rw    : c_rw;
            m_wdata <= grant_d ? d_wdata : c_wdata;
            cnt     <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (m_rw) begin
            if (owner) begin
              d_rdata <= m_rdata;
            end else begin
              c_rdata <= m_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
